// File: rtl/io_cond_pkg.sv
// rtl/io_cond_pkg.sv - shared constants and helpers for board I/O conditioning
package io_cond_pkg;

    localparam int DEFAULT_PRESCALE_LIMIT = 6;
    localparam int DEFAULT_STABLE_TICKS   = 4;
    localparam int BOARD_IO_WIDTH         = 24;
    localparam int RST_PIN                = 23;

    // Width needed to hold values 0..n-1, never less than one bit.
    function automatic int width_of(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/io_debounce_tick_gen.sv
// rtl/io_debounce_tick_gen.sv - free-running prescaler producing a periodic sample strobe
//
// Ports:
//   clk   - sole clock
//   rst_n - synchronous active-low reset
//   tick  - high for one cycle every LIMIT+1 cycles (every cycle when LIMIT is 0)
module tick_gen
    import io_cond_pkg::*;
#(
    parameter int LIMIT = DEFAULT_PRESCALE_LIMIT
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int PW = width_of(LIMIT + 1);

    logic [PW-1:0] pc_q;
    logic [PW-1:0] pc_d;

    assign tick = (pc_q == PW'(LIMIT));

    always_comb begin
        pc_d = pc_q + PW'(1);
        if (tick) begin
            pc_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/io_debounce.sv
// rtl/io_debounce.sv - pad synchroniser and debouncer with rise/fall pulse outputs
//
// Ports:
//   clk   - sole clock
//   rst_n - synchronous active-low reset
//   io_in - raw asynchronous pad levels
//   clean - debounced registered levels
//   rise  - one-cycle pulse on each 0->1 change of clean
//   fall  - one-cycle pulse on each 1->0 change of clean
//   tick  - shared sample strobe
module io_debounce
    import io_cond_pkg::*;
#(
    parameter int WIDTH          = BOARD_IO_WIDTH,
    parameter int PRESCALE_LIMIT = DEFAULT_PRESCALE_LIMIT,
    parameter int STABLE_TICKS   = DEFAULT_STABLE_TICKS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] io_in,
    output logic [WIDTH-1:0] clean,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             tick
);

    localparam int CW = width_of(STABLE_TICKS);

    tick_gen #(
        .LIMIT (PRESCALE_LIMIT)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        logic          s1_q;
        logic          s2_q;
        logic          clean_q;
        logic          clean_d;
        logic          rise_q;
        logic          rise_d;
        logic          fall_q;
        logic          fall_d;
        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;

        always_comb begin
            clean_d = clean_q;
            cnt_d   = cnt_q;
            rise_d  = 1'b0;
            fall_d  = 1'b0;
            if (tick) begin
                if (s2_q == clean_q) begin
                    // Sample agrees with the output: any partial run was a glitch.
                    cnt_d = '0;
                end else if (cnt_q == CW'(STABLE_TICKS - 1)) begin
                    clean_d = s2_q;
                    cnt_d   = '0;
                    rise_d  = s2_q;
                    fall_d  = ~s2_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                s1_q    <= 1'b0;
                s2_q    <= 1'b0;
                clean_q <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
                cnt_q   <= '0;
            end else begin
                s1_q    <= io_in[i];
                s2_q    <= s1_q;
                clean_q <= clean_d;
                rise_q  <= rise_d;
                fall_q  <= fall_d;
                cnt_q   <= cnt_d;
            end
        end

        assign clean[i] = clean_q;
        assign rise[i]  = rise_q;
        assign fall[i]  = fall_q;
    end

endmodule

// File: tb/tb_io_debounce.sv
// tb/tb_io_debounce.sv - self-checking bench for io_debounce
module tb_io_debounce;
    import io_cond_pkg::*;

    localparam int W = 24;

    typedef struct {
        logic [W-1:0] pad;
        int           hold;
        logic [W-1:0] exp_clean;
        logic [W-1:0] exp_rise;
        logic [W-1:0] exp_fall;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] io_in;
    logic [W-1:0] clean, rise, fall;
    logic         tick;
    logic [W-1:0] io1;
    logic [W-1:0] clean1, rise1, fall1;
    logic         tick1;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    io_debounce #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io_in (io_in),
        .clean (clean),
        .rise  (rise),
        .fall  (fall),
        .tick  (tick)
    );

    io_debounce #(.WIDTH(W), .PRESCALE_LIMIT(0), .STABLE_TICKS(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .io_in (io1),
        .clean (clean1),
        .rise  (rise1),
        .fall  (fall1),
        .tick  (tick1)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    vec_t         vecs[7];
    logic [W-1:0] hist[40];

    function automatic logic [W-1:0] hist_at(input int k);
        return (k < 0) ? '0 : hist[k];
    endfunction

    initial begin
        logic [W-1:0] seen_r, seen_f, multi, first_rise;
        int first, rcnt, fcnt, other;

        vecs[0] = '{24'h000000, 40, 24'h000000, 24'h000000, 24'hFFFFFF};
        vecs[1] = '{24'h00F00F, 40, 24'h00F00F, 24'h00F00F, 24'h000000};
        vecs[2] = '{24'h00F000, 40, 24'h00F000, 24'h000000, 24'h00000F};
        vecs[3] = '{24'h80F000, 12, 24'h00F000, 24'h000000, 24'h000000};
        vecs[4] = '{24'h00F000, 40, 24'h00F000, 24'h000000, 24'h000000};
        vecs[5] = '{24'hFFFFFF, 40, 24'hFFFFFF, 24'hFF0FFF, 24'h000000};
        vecs[6] = '{24'h000000, 40, 24'h000000, 24'h000000, 24'hFFFFFF};

        // Reset with all pads high
        rst_n = 1'b0;
        io_in = '1;
        io1   = '0;
        repeat (5) begin
            @(negedge clk);
            chk("reset_clean", clean, '0);
            chk("reset_rise", rise, '0);
            chk("reset_fall", fall, '0);
            chk("reset_tick", {23'd0, tick}, '0);
        end
        rst_n = 1'b1;
        first = 0; rcnt = 0; other = 0; fcnt = 0;
        for (int n = 1; n <= 35; n++) begin
            @(negedge clk);
            if (first == 0 && clean == '1) first = n;
            if (rise == '1) rcnt++;
            else if (rise != '0) other++;
            if (fall != '0) fcnt++;
        end
        chk_range("release_latency", first, 1, 30);
        chk_range("release_rise_cycles", rcnt, 1, 1);
        chk_range("release_partial_rise", other, 0, 0);
        chk_range("release_fall", fcnt, 0, 0);

        // Table of level patterns
        for (int v = 0; v < 7; v++) begin
            io_in  = vecs[v].pad;
            seen_r = '0; seen_f = '0; multi = '0;
            repeat (vecs[v].hold) begin
                @(negedge clk);
                multi  |= (seen_r & rise) | (seen_f & fall);
                seen_r |= rise;
                seen_f |= fall;
            end
            chk($sformatf("vec%0d_clean", v), clean, vecs[v].exp_clean);
            chk($sformatf("vec%0d_rise", v), seen_r, vecs[v].exp_rise);
            chk($sformatf("vec%0d_fall", v), seen_f, vecs[v].exp_fall);
            chk($sformatf("vec%0d_single_pulse", v), multi, '0);
        end

        // Simultaneous rise on eight channels
        io_in = 24'h00F00F;
        first_rise = '0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (first_rise == '0) first_rise = rise;
        end
        chk("simultaneous_rise", first_rise, 24'h00F00F);
        io_in = '0;
        repeat (40) @(negedge clk);

        // Clean step up and down on the reset pin
        repeat ($urandom_range(0, 13)) @(negedge clk);
        io_in[RST_PIN] = 1'b1;
        first = 0; rcnt = 0; fcnt = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (first == 0 && clean[RST_PIN]) first = n;
            rcnt += int'(rise[RST_PIN]);
            if (fall != '0) fcnt++;
        end
        chk_range("step_up_latency", first, 24, 30);
        chk_range("step_up_rise_count", rcnt, 1, 1);
        chk_range("step_up_fall", fcnt, 0, 0);
        repeat ($urandom_range(0, 13)) @(negedge clk);
        io_in[RST_PIN] = 1'b0;
        first = 0; rcnt = 0; fcnt = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (first == 0 && !clean[RST_PIN]) first = n;
            fcnt += int'(fall[RST_PIN]);
            if (rise != '0) rcnt++;
        end
        chk_range("step_down_latency", first, 24, 30);
        chk_range("step_down_fall_count", fcnt, 1, 1);
        chk_range("step_down_rise", rcnt, 0, 0);

        // 10-cycle glitch on pad 0
        io_in[0] = 1'b1;
        rcnt = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (n == 9) io_in[0] = 1'b0;
            if (clean[0] || rise[0] || fall[0]) rcnt++;
        end
        chk_range("glitch_trace", rcnt, 0, 0);

        // Bounce train then steady high
        rcnt = 0;
        for (int n = 0; n < 140; n++) begin
            io_in[0] = (n >= 100) ? 1'b1 : ((n / 5) % 2 == 0);
            @(negedge clk);
            rcnt += int'(rise[0]);
        end
        chk_range("bounce_rise_count", rcnt, 1, 1);
        chk("bounce_final_clean", {23'd0, clean[0]}, 24'h000001);
        io_in[0] = 1'b0;
        repeat (40) @(negedge clk);
        chk("bounce_release_clean", clean, '0);

        // Reset in the middle of a debounce
        io_in[5] = 1'b1;
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midreset_clean", clean, '0);
        chk("midreset_rise", rise, '0);
        rst_n = 1'b1;
        first = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (first == 0 && clean[5]) first = n;
        end
        chk_range("midreset_latency", first, 24, 30);
        io_in = '0;
        repeat (40) @(negedge clk);

        // Degenerate parameters: clean follows the pad three cycles later
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            chk($sformatf("p0_clean_%0d", j), clean1, hist_at(j - 3));
            chk($sformatf("p0_rise_%0d", j), rise1, hist_at(j - 3) & ~hist_at(j - 4));
            chk($sformatf("p0_fall_%0d", j), fall1, ~hist_at(j - 3) & hist_at(j - 4));
            chk($sformatf("p0_tick_%0d", j), {23'd0, tick1}, 24'h000001);
            if (j == 0)           io1 = 24'h00F00F;
            else if (j % 3 == 0)  io1 = W'($urandom);
            hist[j] = io1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
